// File: rtl/dff_bank_arbiter_if.sv
// Bus between the requesters and dff_bank_arbiter: request/data in, grant/ack and shared register out.
// Parameters NREQ and WIDTH must match the arbiter instance that binds the slave modport.
interface dff_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  // Handshake: requester i raises req[i] with data_in[i*WIDTH +: WIDTH] and holds both stable
  // until it sees ack with gnt[i]; it drops req on the following cycle. A req still high when
  // the arbiter is idle is treated as a new request. gnt is one-hot and ack is a one-cycle pulse.
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       gnt;
  logic                  ack;
  logic                  busy;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qb;

  modport master (output req, data_in, input gnt, ack, busy, q, qb);
  modport slave  (input req, data_in, output gnt, ack, busy, q, qb);
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter in front of one shared WIDTH-bit register (q/qb), three cycles per write.
// Define DFF_ARB_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins priority.
module dff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  dff_bank_arbiter_if.slave   bus,
  output logic [1:0]          dbg_state_o
);
  localparam int PW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;

  logic [PW-1:0]    pick;
  logic             req_w;
  logic [WIDTH-1:0] data_w;

`ifdef DFF_ARB_FIXED_PRIORITY_EN
  always_comb begin : arbitrate
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) pick = PW'(i);
    end
  end
`else
  // Search starts just after the last served requester and wraps around.
  always_comb begin : arbitrate
    logic found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req[(int'(ptr_q) + k) % NREQ]) begin
        pick  = PW'((int'(ptr_q) + k) % NREQ);
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin : winner_mux
    req_w  = 1'b0;
    data_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_q == PW'(i)) begin
        req_w  = bus.req[i];
        data_w = bus.data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = 1'b0;
    q_d     = q_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (|bus.req) begin
          win_d   = pick;
          gnt_d   = NREQ'(1) << pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // A withdrawn request abandons the slot without touching the register or the pointer.
        if (req_w) begin
          q_d     = data_w;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        ptr_d   = win_q;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ack_q   <= 1'b0;
      q_q     <= '0;
      ptr_q   <= PW'(NREQ - 1);
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.q       = q_q;
  assign bus.qb      = ~q_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter (NREQ=4, WIDTH=8): directed vectors, corner sequences, randomized traffic.
module tb_dff_bank_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         n_cmp = 0;
  int         n_err = 0;

  dff_bank_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

  dff_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        ack;
    logic        busy;
    logic [7:0]  q;
  } vec_t;

  vec_t vecs[15];

  // Scoreboard entries: {gnt[3:0], ack, busy, q[7:0]}
  logic [13:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic a,
                           input logic b, input logic [7:0] qv);
    logic [7:0] nq;
    nq = ~qv;
    check({tag, ".gnt"},  32'(bus.gnt),  32'(g));
    check({tag, ".ack"},  32'(bus.ack),  32'(a));
    check({tag, ".busy"}, 32'(bus.busy), 32'(b));
    check({tag, ".q"},    32'(bus.q),    32'(qv));
    check({tag, ".qb"},   32'(bus.qb),   32'(nq));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] r, input logic [31:0] d);
    bus.req     = r;
    bus.data_in = d;
  endtask

  // Assert reset away from any clock edge and check it takes effect without a clock.
  task automatic reset_dut(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive(4'b0000, 32'h0);
    #1;
    check_out(tag, 4'b0000, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int pick_w(input logic [3:0] r, input int last);
`ifdef DFF_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
    return -1;
  endfunction

  initial begin
    vecs[0]  = '{4'b1111, 32'h13121110, 4'b0001, 1'b0, 1'b1, 8'h00};
    vecs[1]  = '{4'b1111, 32'h13121110, 4'b0001, 1'b1, 1'b1, 8'h10};
    vecs[2]  = '{4'b1111, 32'h13121110, 4'b0000, 1'b0, 1'b0, 8'h10};
    vecs[3]  = '{4'b1111, 32'h13121110, 4'b0010, 1'b0, 1'b1, 8'h10};
    vecs[4]  = '{4'b1111, 32'h13121110, 4'b0010, 1'b1, 1'b1, 8'h11};
    vecs[5]  = '{4'b1111, 32'h13121110, 4'b0000, 1'b0, 1'b0, 8'h11};
    vecs[6]  = '{4'b1111, 32'h13121110, 4'b0100, 1'b0, 1'b1, 8'h11};
    vecs[7]  = '{4'b1111, 32'h13121110, 4'b0100, 1'b1, 1'b1, 8'h12};
    vecs[8]  = '{4'b1111, 32'h13121110, 4'b0000, 1'b0, 1'b0, 8'h12};
    vecs[9]  = '{4'b1111, 32'h13121110, 4'b1000, 1'b0, 1'b1, 8'h12};
    vecs[10] = '{4'b1111, 32'h13121110, 4'b1000, 1'b1, 1'b1, 8'h13};
    vecs[11] = '{4'b1111, 32'h13121110, 4'b0000, 1'b0, 1'b0, 8'h13};
    vecs[12] = '{4'b1111, 32'h13121110, 4'b0001, 1'b0, 1'b1, 8'h13};
    vecs[13] = '{4'b1111, 32'h13121110, 4'b0001, 1'b1, 1'b1, 8'h10};
    vecs[14] = '{4'b1111, 32'h13121110, 4'b0000, 1'b0, 1'b0, 8'h10};

    drive(4'b0000, 32'h0);
    #12;
    rst_n = 1'b1;
    tick();
    check_out("idle_after_reset", 4'b0000, 1'b0, 1'b0, 8'h00);

    // Single write from requester 2
    drive(4'b0100, 32'h00A50000);
    tick();
    check_out("single.grant", 4'b0100, 1'b0, 1'b1, 8'h00);
    tick();
    check_out("single.ack", 4'b0100, 1'b1, 1'b1, 8'hA5);
    drive(4'b0000, 32'h0);
    tick();
    check_out("single.idle", 4'b0000, 1'b0, 1'b0, 8'hA5);
    reset_dut("reset_mid_sim");

`ifndef DFF_ARB_FIXED_PRIORITY_EN
    // Round-robin with all four requesters held
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].req, vecs[i].data);
      tick();
      check_out($sformatf("rr[%0d]", i), vecs[i].gnt, vecs[i].ack, vecs[i].busy, vecs[i].q);
    end

    // Withdrawal during GRANT: no write, pointer stays on requester 0
    drive(4'b0010, 32'h00004400);
    tick();
    check_out("wd.grant", 4'b0010, 1'b0, 1'b1, 8'h10);
    drive(4'b0000, 32'h0);
    tick();
    check_out("wd.dropped", 4'b0000, 1'b0, 1'b0, 8'h10);
    drive(4'b1111, 32'h13121110);
    tick();
    check_out("wd.next_grant", 4'b0010, 1'b0, 1'b1, 8'h10);
    tick();
    check_out("wd.next_ack", 4'b0010, 1'b1, 1'b1, 8'h11);
    drive(4'b0000, 32'h0);
    tick();
    check_out("wd.next_idle", 4'b0000, 1'b0, 1'b0, 8'h11);
`else
    // Fixed priority: requester 1 always beats requester 3
    drive(4'b1010, 32'h88007700);
    for (int r = 0; r < 4; r++) begin
      tick();
      check_out($sformatf("fp[%0d].grant", r), 4'b0010, 1'b0, 1'b1, (r == 0) ? 8'h00 : 8'h77);
      tick();
      check_out($sformatf("fp[%0d].ack", r), 4'b0010, 1'b1, 1'b1, 8'h77);
      tick();
      check_out($sformatf("fp[%0d].idle", r), 4'b0000, 1'b0, 1'b0, 8'h77);
    end
`endif

    // Reset while in GRANT discards the pending write and restarts arbitration at requester 0
    reset_dut("reset_pre_grant");
    drive(4'b1001, 32'h7700003C);
    tick();
    check_out("rg.grant", 4'b0001, 1'b0, 1'b1, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rg.in_reset", 4'b0000, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_out("rg.regrant", 4'b0001, 1'b0, 1'b1, 8'h00);
    tick();
    check_out("rg.ack", 4'b0001, 1'b1, 1'b1, 8'h3C);
    drive(4'b0000, 32'h0);
    tick();
    check_out("rg.idle", 4'b0000, 1'b0, 1'b0, 8'h3C);

    // Randomized traffic against a transaction-level model
    reset_dut("reset_pre_random");
    begin
      logic [3:0]  pending;
      logic [3:0]  cool;
      logic [7:0]  dat[4];
      logic [7:0]  model_q;
      logic [13:0] e;
      logic [3:0]  oh;
      int          last;
      int          w;
      pending = '0;
      cool    = '0;
      model_q = 8'h00;
      last    = 3;
      for (int i = 0; i < 4; i++) dat[i] = 8'h00;
      exp_q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
        for (int i = 0; i < 4; i++) begin
          if (!pending[i] && !cool[i] && $urandom_range(0, 2) == 0) begin
            pending[i] = 1'b1;
            dat[i]     = 8'($urandom_range(0, 255));
          end
          cool[i] = 1'b0;
        end
        drive(pending, {dat[3], dat[2], dat[1], dat[0]});
        tick();
        if (exp_q.size() == 0) begin
          w = pick_w(pending, last);
          if (w < 0) begin
            exp_q.push_back({4'b0000, 1'b0, 1'b0, model_q});
          end else begin
            oh = 4'(1 << w);
            exp_q.push_back({oh, 1'b0, 1'b1, model_q});
            exp_q.push_back({oh, 1'b1, 1'b1, dat[w]});
            exp_q.push_back({4'b0000, 1'b0, 1'b0, dat[w]});
            model_q = dat[w];
            last    = w;
          end
        end
        e = exp_q.pop_front();
        check_out("rand", e[13:10], e[9], e[8], e[7:0]);
        // The acked requester drops its request on the next cycle
        if (e[9]) begin
          pending = pending & ~e[13:10];
          cool    = e[13:10];
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
